// File: rtl/adc_spi_arbiter.sv
// Two-requester round-robin arbiter in front of a 3-wire SPI ADC register port.
// Each 24-bit command is shifted MSB first; reads turn the SDIO line around for the final byte.
//
// state | meaning
// IDLE  | arbitrate every cycle; the winner's ready pulses combinationally
// START | wait for a tick, then drop cs and load the bit counter
// HIGH  | sck low with the data bit presented; tick raises sck and samples read bits
// LOW   | sck high; tick lowers sck and steps to the next bit
// STOP  | raise cs and take back the SDIO line
// DONE  | publish read data to the owner and pulse its done
module adc_spi_arbiter #(
  parameter int PRESCALER       = 5,
  parameter int PRESCALER_WIDTH = 3
) (
  input  logic        aclk,
  input  logic        reset,
  input  logic        req0_valid,
  input  logic [23:0] req0_data,
  output logic        req0_ready,
  output logic        req0_done,
  output logic [7:0]  req0_rdata,
  input  logic        req1_valid,
  input  logic [23:0] req1_data,
  output logic        req1_ready,
  output logic        req1_done,
  output logic [7:0]  req1_rdata,
  output logic        busy,
  output logic        spi_sck,
  output logic        spi_cs,
  output logic        spi_sdio_o,
  output logic        spi_sdio_t,
  input  logic        spi_sdio_i
);

  typedef enum logic [2:0] {IDLE, START, HIGH, LOW, STOP, DONE} state_t;

  localparam logic [PRESCALER_WIDTH-1:0] TICK_MAX = PRESCALER_WIDTH'(PRESCALER - 1);

  logic [PRESCALER_WIDTH-1:0] tick_cnt;
  logic                       tick;
  state_t                     state, state_d;
  logic [23:0]                cmd, cmd_d;
  logic [4:0]                 bit_cnt, bit_cnt_d;
  logic [7:0]                 shadow, shadow_d;
  logic [7:0]                 rdata0_d, rdata1_d;
  logic                       owner, owner_d;
  logic                       last_grant, last_grant_d;
  logic                       sck_d, cs_d, sdio_t_d;
  logic                       done0_d, done1_d;
  logic                       win1, rw;

  always_ff @(posedge aclk or posedge reset) begin
    if (reset)     tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else           tick_cnt <= tick_cnt + 1'b1;
  end

  assign tick = (tick_cnt == TICK_MAX);
  assign rw   = cmd[23];
  assign busy = (state != IDLE);

  // last_grant holds the most recent winner; a tie goes to the other requester
  assign win1 = req1_valid & (~req0_valid | ~last_grant);

  assign spi_sdio_o = ~spi_cs & ~spi_sdio_t & cmd[bit_cnt];

  always_ff @(posedge aclk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cmd        <= '0;
      bit_cnt    <= '0;
      shadow     <= '0;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      spi_sck    <= 1'b0;
      spi_cs     <= 1'b1;
      spi_sdio_t <= 1'b0;
      req0_done  <= 1'b0;
      req1_done  <= 1'b0;
      req0_rdata <= '0;
      req1_rdata <= '0;
    end else begin
      state      <= state_d;
      cmd        <= cmd_d;
      bit_cnt    <= bit_cnt_d;
      shadow     <= shadow_d;
      owner      <= owner_d;
      last_grant <= last_grant_d;
      spi_sck    <= sck_d;
      spi_cs     <= cs_d;
      spi_sdio_t <= sdio_t_d;
      req0_done  <= done0_d;
      req1_done  <= done1_d;
      req0_rdata <= rdata0_d;
      req1_rdata <= rdata1_d;
    end
  end

  always_comb begin
    state_d      = state;
    cmd_d        = cmd;
    bit_cnt_d    = bit_cnt;
    shadow_d     = shadow;
    owner_d      = owner;
    last_grant_d = last_grant;
    sck_d        = spi_sck;
    cs_d         = spi_cs;
    sdio_t_d     = spi_sdio_t;
    rdata0_d     = req0_rdata;
    rdata1_d     = req1_rdata;
    done0_d      = 1'b0;
    done1_d      = 1'b0;
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;
    case (state)
      IDLE: begin
        if (req0_valid || req1_valid) begin
          req0_ready   = ~win1;
          req1_ready   = win1;
          cmd_d        = win1 ? req1_data : req0_data;
          owner_d      = win1;
          last_grant_d = win1;
          state_d      = START;
        end
      end
      START: begin
        if (tick) begin
          cs_d      = 1'b0;
          bit_cnt_d = 5'd23;
          state_d   = HIGH;
        end
      end
      HIGH: begin
        if (tick) begin
          sck_d = 1'b1;
          if (rw && bit_cnt <= 5'd7) shadow_d[bit_cnt[2:0]] = spi_sdio_i;
          state_d = LOW;
        end
      end
      LOW: begin
        if (tick) begin
          sck_d = 1'b0;
          if (bit_cnt == 5'd0) begin
            state_d = STOP;
          end else begin
            bit_cnt_d = bit_cnt - 5'd1;
            state_d   = HIGH;
            // counter about to reach 7: release SDIO so the ADC can drive the data byte
            if (rw && bit_cnt <= 5'd8) sdio_t_d = 1'b1;
          end
        end
      end
      STOP: begin
        if (tick) begin
          cs_d     = 1'b1;
          sdio_t_d = 1'b0;
          state_d  = DONE;
        end
      end
      DONE: begin
        if (tick) begin
          if (owner) begin
            done1_d = 1'b1;
            if (rw) rdata1_d = shadow;
          end else begin
            done0_d = 1'b1;
            if (rw) rdata0_d = shadow;
          end
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_adc_spi_arbiter.sv
// Scoreboard bench for adc_spi_arbiter: stimulus queues expected grants/transactions,
// negedge monitors pop and compare on ready and done pulses.
module tb_adc_spi_arbiter;

  logic        aclk  = 1'b0;
  logic        reset = 1'b1;
  logic        req0_valid, req1_valid;
  logic [23:0] req0_data, req1_data;
  logic        req0_ready, req1_ready, req0_done, req1_done;
  logic [7:0]  req0_rdata, req1_rdata;
  logic        busy, spi_sck, spi_cs, spi_sdio_o, spi_sdio_t;
  logic        spi_sdio_i = 1'b0;

  logic        s_valid = 1'b0;
  logic        s_ready0, s_ready1, s_done0, s_done1;
  logic [7:0]  s_rd0, s_rd1;
  logic        s_busy, s_sck, s_cs, s_sdo, s_sdt;

  adc_spi_arbiter #(.PRESCALER(2), .PRESCALER_WIDTH(3)) u_dut (
    .aclk(aclk), .reset(reset),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req0_done(req0_done), .req0_rdata(req0_rdata),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .req1_done(req1_done), .req1_rdata(req1_rdata),
    .busy(busy), .spi_sck(spi_sck), .spi_cs(spi_cs),
    .spi_sdio_o(spi_sdio_o), .spi_sdio_t(spi_sdio_t), .spi_sdio_i(spi_sdio_i)
  );

  adc_spi_arbiter #(.PRESCALER(5), .PRESCALER_WIDTH(3)) u_slow (
    .aclk(aclk), .reset(reset),
    .req0_valid(s_valid), .req0_data(24'h000503), .req0_ready(s_ready0),
    .req0_done(s_done0), .req0_rdata(s_rd0),
    .req1_valid(1'b0), .req1_data(24'h000000), .req1_ready(s_ready1),
    .req1_done(s_done1), .req1_rdata(s_rd1),
    .busy(s_busy), .spi_sck(s_sck), .spi_cs(s_cs),
    .spi_sdio_o(s_sdo), .spi_sdio_t(s_sdt), .spi_sdio_i(1'b0)
  );

  always #5 aclk = ~aclk;

  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, req);
    end
  endtask

  task automatic fail_event(input string name);
    checks++;
    errors++;
    $display("FAIL %s: actual none-or-unexpected required expected-event", name);
  endtask

  typedef struct {
    int          id;
    logic [23:0] cmd;
    logic [7:0]  rd0;
    logic [7:0]  rd1;
  } txn_t;

  int         grant_q[$];
  txn_t       done_q[$];
  logic [7:0] rd_model [2];
  logic [7:0] slave_byte = 8'h00;
  int         grants = 0;
  int         fcnt = 0;

  task automatic expect_txn(input int id, input logic [23:0] cmd);
    txn_t t;
    if (cmd[23]) rd_model[id] = slave_byte;
    t.id  = id;
    t.cmd = cmd;
    t.rd0 = rd_model[0];
    t.rd1 = rd_model[1];
    grant_q.push_back(id);
    done_q.push_back(t);
  endtask

  // ADC slave: counts sck falls and drives slave_byte MSB first while SDIO is released
  initial begin
    logic sp;
    int   idx;
    sp = 1'b0;
    forever begin
      @(negedge aclk);
      if (spi_cs) fcnt = 0;
      else if (sp && !spi_sck) fcnt++;
      sp  = spi_sck;
      idx = 23 - fcnt;
      spi_sdio_i = (!spi_cs && fcnt >= 16 && fcnt <= 23) ? slave_byte[idx[2:0]] : 1'b0;
    end
  end

  // main monitor: done first, since a back-to-back grant shares the done cycle
  initial begin
    logic        sck_prev;
    logic [23:0] frame, tmask;
    int          nbits, gcyc, lat;
    bit          bad_ready;
    txn_t        t;
    sck_prev = 1'b0; frame = '0; tmask = '0; nbits = 0; gcyc = 0; bad_ready = 1'b0;
    forever begin
      @(negedge aclk);
      if (reset) begin
        sck_prev = 1'b0;
      end else begin
        if (busy && (req0_ready || req1_ready)) bad_ready = 1'b1;
        if (req0_done || req1_done) begin
          if (done_q.size() == 0) begin
            fail_event("unexpected_done");
          end else begin
            t   = done_q.pop_front();
            lat = cyc - gcyc;
            check("done_id", 32'({req1_done, req0_done}), (t.id != 0) ? 32'd2 : 32'd1);
            check("frame_bits", 32'(frame), t.cmd[23] ? 32'({t.cmd[23:8], 8'h00}) : 32'(t.cmd));
            check("sdio_t_bits", 32'(tmask), t.cmd[23] ? 32'h0000_00FF : 32'h0);
            check("sck_rising_edges", 32'(nbits), 32'd24);
            check("rdata0", 32'(req0_rdata), 32'(t.rd0));
            check("rdata1", 32'(req1_rdata), 32'(t.rd1));
            check("latency_102_103", 32'(lat >= 102 && lat <= 103), 32'd1);
            check("ready_only_idle", 32'(bad_ready), 32'd0);
          end
        end
        if (req0_ready || req1_ready) begin
          check("single_ready", 32'(req0_ready & req1_ready), 32'd0);
          grants++;
          if (grant_q.size() == 0) fail_event("unexpected_grant");
          else check("grant_id", 32'(req1_ready), 32'(grant_q.pop_front()));
          gcyc = cyc; frame = '0; tmask = '0; nbits = 0; bad_ready = 1'b0;
        end
        if (spi_sck && !sck_prev) begin
          frame = {frame[22:0], spi_sdio_o};
          tmask = {tmask[22:0], spi_sdio_t};
          nbits++;
        end
        sck_prev = spi_sck;
      end
    end
  end

  // PRESCALER=5 instance: sck high width and cs gap between back-to-back writes
  int s_grants = 0, s_dones = 0, s_widths = 0, s_bad_w = 0, s_min_gap = 1000;
  bit slow_done = 1'b0;

  initial begin
    int   hi_run, cs_run;
    bit   seen_fall;
    logic sck_p, cs_p;
    hi_run = 0; cs_run = 0; seen_fall = 1'b0; sck_p = 1'b0; cs_p = 1'b1;
    forever begin
      @(negedge aclk);
      if (!reset) begin
        if (s_ready0) s_grants++;
        if (s_done0) s_dones++;
        if (s_sck) hi_run++;
        else if (sck_p) begin
          s_widths++;
          if (hi_run != 5) s_bad_w++;
          hi_run = 0;
        end
        if (s_cs) cs_run++;
        else if (cs_p) begin
          if (seen_fall && cs_run < s_min_gap) s_min_gap = cs_run;
          seen_fall = 1'b1;
          cs_run = 0;
        end
        sck_p = s_sck;
        cs_p  = s_cs;
      end
    end
  end

  initial begin
    @(negedge reset);
    @(posedge aclk); #1;
    s_valid = 1'b1;
    for (int i = 0; i < 3000 && s_grants < 2; i++) @(negedge aclk);
    @(posedge aclk); #1;
    s_valid = 1'b0;
    for (int i = 0; i < 3000 && s_dones < 2; i++) @(negedge aclk);
    repeat (10) @(negedge aclk);
    check("slow_done_count", 32'(s_dones), 32'd2);
    check("slow_sck_pulses", 32'(s_widths), 32'd48);
    check("slow_sck_high_5", 32'(s_bad_w), 32'd0);
    check("slow_cs_gap_ge5", 32'(s_min_gap >= 5), 32'd1);
    slow_done = 1'b1;
  end

  task automatic wait_idle();
    for (int i = 0; i < 2000 && (done_q.size() != 0 || busy); i++) @(negedge aclk);
    if (done_q.size() != 0 || busy) fail_event("done_timeout");
    @(posedge aclk); #1;
  endtask

  task automatic issue(input int id, input logic [23:0] cmd);
    bit idle_now, got;
    got = 1'b0;
    expect_txn(id, cmd);
    @(posedge aclk); #1;
    idle_now = !busy;
    if (id == 0) begin req0_data = cmd; req0_valid = 1'b1; end
    else         begin req1_data = cmd; req1_valid = 1'b1; end
    #1;
    if (idle_now) check("grant_same_cycle", 32'((id == 0) ? req0_ready : req1_ready), 32'd1);
    for (int i = 0; i < 2000 && !got; i++) begin
      @(negedge aclk);
      got = (id == 0) ? req0_ready : req1_ready;
    end
    if (!got) fail_event("ready_timeout");
    @(posedge aclk); #1;
    if (id == 0) req0_valid = 1'b0;
    else         req1_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: actual still running required finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    req0_valid = 1'b0; req1_valid = 1'b0; req0_data = '0; req1_data = '0;
    rd_model[0] = 8'h00; rd_model[1] = 8'h00;
    repeat (3) @(posedge aclk); #1;
    check("rst_cs", 32'(spi_cs), 32'd1);
    check("rst_sck", 32'(spi_sck), 32'd0);
    check("rst_sdio_o", 32'(spi_sdio_o), 32'd0);
    check("rst_sdio_t", 32'(spi_sdio_t), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ready", 32'({req1_ready, req0_ready}), 32'd0);
    check("rst_done", 32'({req1_done, req0_done}), 32'd0);
    check("rst_rdata0", 32'(req0_rdata), 32'd0);
    check("rst_rdata1", 32'(req1_rdata), 32'd0);
    @(posedge aclk); #1;
    reset = 1'b0;

    // both requesters hold valid: grants alternate 0,1,0,1
    expect_txn(0, 24'h0012A5);
    expect_txn(1, 24'h401234);
    expect_txn(0, 24'h0012A5);
    expect_txn(1, 24'h401234);
    @(posedge aclk); #1;
    req0_data = 24'h0012A5; req1_data = 24'h401234;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    check("tie_first_req0", 32'({req1_ready, req0_ready}), 32'd1);
    for (int i = 0; i < 2000 && grants < 4; i++) @(negedge aclk);
    if (grants < 4) fail_event("alternate_grant_timeout");
    @(posedge aclk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_idle();

    issue(0, 24'h000503);
    wait_idle();

    slave_byte = 8'h88;
    issue(1, 24'h800001);
    wait_idle();

    // req1 pulses valid while req0 owns the bus: no grant may result
    issue(0, 24'h00C03C);
    repeat (20) @(posedge aclk); #1;
    req1_data = 24'h8ABCDE; req1_valid = 1'b1;
    repeat (3) @(posedge aclk); #1;
    req1_valid = 1'b0;
    wait_idle();

    slave_byte = 8'h3C;
    issue(1, 24'h8ABCDE);
    wait_idle();

    for (int i = 0; i < 3000 && !slow_done; i++) @(negedge aclk);
    if (!slow_done) fail_event("slow_timeout");

    // abort during HIGH of bit 10 (13 sck falls seen)
    expect_txn(0, 24'h0A5A5A);
    grant_q.delete();
    grant_q.push_back(0);
    @(posedge aclk); #1;
    req0_data = 24'h0A5A5A; req0_valid = 1'b1;
    @(posedge aclk); #1;
    req0_valid = 1'b0;
    for (int i = 0; i < 2000 && fcnt != 13; i++) @(negedge aclk);
    if (fcnt != 13) fail_event("bit10_timeout");
    #2;
    check("pre_abort_cs", 32'(spi_cs), 32'd0);
    check("pre_abort_sck", 32'(spi_sck), 32'd0);
    reset = 1'b1;
    #1;
    check("abort_cs", 32'(spi_cs), 32'd1);
    check("abort_sck", 32'(spi_sck), 32'd0);
    check("abort_sdio_t", 32'(spi_sdio_t), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_rdata1", 32'(req1_rdata), 32'd0);
    done_q.delete();
    grant_q.delete();
    rd_model[0] = 8'h00; rd_model[1] = 8'h00;
    repeat (3) @(posedge aclk); #1;
    reset = 1'b0;
    repeat (10) @(posedge aclk); #1;

    issue(0, 24'h000803);
    wait_idle();

    repeat (5) @(posedge aclk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/adc_spi_arbiter.md
ADC_SPI_ARBITER -- requirements
Module: adc_spi_arbiter

Interface
REQ-001 SHALL have parameter PRESCALER, default 5: aclk cycles per SPI tick; legal range 2..2^PRESCALER_WIDTH.
REQ-002 SHALL have parameter PRESCALER_WIDTH, default 3: width of the tick counter.
REQ-003 SHALL have port aclk  in  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-005 SHALL have ports req0_valid/req1_valid  in  1  command request.
REQ-006 SHALL have ports req0_data/req1_data  in  24  command word: bit23 = RW (1 = read), bits22:21 = W, bits20:8 = address, bits7:0 = write data.
REQ-007 SHALL have ports req0_ready/req1_ready  out  1  one-cycle grant and accept pulse.
REQ-008 SHALL have ports req0_done/req1_done  out  1  one-cycle completion pulse.
REQ-009 SHALL have ports req0_rdata/req1_rdata  out  8  read-back byte, valid from the done pulse until that requester's next done.
REQ-010 SHALL have port busy  out  1  high whenever state != IDLE.
REQ-011 SHALL have ports spi_sck, spi_cs  out  1  SPI clock (idle 0) and chip select (active low).
REQ-012 SHALL have ports spi_sdio_o  out  1, spi_sdio_t  out  1 (1 = release the line), spi_sdio_i  in  1: 3-wire SDIO, with the pad buffer external.

Function
REQ-013 Tick generator: counter runs 0..PRESCALER-1; tick is a one-cycle pulse when the count equals PRESCALER-1; free-running.
REQ-014 FSM states: IDLE, START, HIGH, LOW, STOP, DONE; every transition except out of IDLE occurs only on tick.
REQ-015 IDLE arbitration, on any aclk cycle (not tick-gated):
  - If any valid: assert the winner's ready for exactly one cycle, latch its data into the shift register, record the winner, go to START.
  - Only one valid: that requester wins.
REQ-016 Round-robin on a tie: the requester not granted last wins; the pointer resets so that req0 wins the first tie.
REQ-017 Ready SHALL be low in every state except the single grant cycle; a requester holds valid and data until ready; deasserting valid before grant is legal.
REQ-018 START: on tick, spi_cs<=0, bit counter<=23, go to HIGH.
REQ-019 HIGH: on tick, spi_sck<=1; if RW=1 and counter<=7, rdata_shadow[counter]<=spi_sdio_i; go to LOW.
REQ-020 LOW: on tick, spi_sck<=0.
  - Counter==0: go to STOP.
  - Otherwise: counter decrements and go to HIGH.
  - If RW=1 and the new counter<=7: spi_sdio_t<=1.
REQ-021 spi_sdio_o SHALL equal shift[counter] while spi_cs=0 and spi_sdio_t=0, else 0; bits go MSB first; 24 rising sck edges per transaction.
REQ-022 STOP: on tick, spi_cs<=1, spi_sdio_t<=0, go to DONE.
REQ-023 DONE: on tick, copy rdata_shadow to the granted requester's rdata, pulse its done one cycle, go to IDLE.
REQ-024 Write transactions SHALL leave rdata unchanged.
REQ-025 Transaction length SHALL be 51 ticks from the first tick after grant to the done pulse; spi_cs stays high for at least 1 tick (DONE) between transactions.
REQ-026 Continuous valid from one requester SHALL yield back-to-back transactions, each re-arbitrated in IDLE.

Reset
REQ-027 On reset assertion, immediately and without waiting for a tick:
  - State = IDLE, tick counter = 0, round-robin pointer = favour req0.
  - spi_cs=1, spi_sck=0, spi_sdio_o=0, spi_sdio_t=0.
  - readyX=0, doneX=0, rdataX=0, busy=0.
REQ-028 Reset mid-transaction SHALL abort it with no done pulse; the first transaction after release SHALL be complete and correct.

Verification (PRESCALER=2 unless stated)
REQ-029 req0 write 0x000503 -> req0_ready 1 cycle; sdio_o shows 0x000503 MSB-first on 24 sck rising edges; req0_done once, 102 cycles later; req1_done never.
REQ-030 req1 read 0x800001; slave model drives 0x88 on the last 8 bits -> spi_sdio_t=1 exactly during those 8 bits; req1_rdata=0x88 at req1_done; req0_rdata stays 0.
REQ-031 Both valid continuously after reset -> grants alternate 0,1,0,1; the losing ready stays 0 during each transaction.
REQ-032 Reset asserted during HIGH of bit 10 -> same cycle spi_cs=1, spi_sck=0, spi_sdio_t=0, busy=0; no done; after release, a write of 0x000803 completes correctly.
REQ-033 PRESCALER=5, single write -> spi_sck high for 5 aclk cycles per bit; spi_cs high for at least 5 cycles between back-to-back transactions.
REQ-034 valid pulsed and dropped while busy from another requester -> no grant; asserted in IDLE -> granted on that same cycle.
